// File: rtl/result_bank.sv
// Result bank: captures a 3x3 result matrix one row per beat, then streams it out serially in row-major order.
// Optional build macro RESULT_BANK_SAT_EN: saturate each word to DW bits instead of truncating.
module result_bank #(
  parameter int RW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          flush,
  input  logic [RW-1:0] res_in1,
  input  logic [RW-1:0] res_in2,
  input  logic [RW-1:0] res_in3,
  input  logic          res_valid,
  output logic          res_ready,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done,
  output logic          busy
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [1:0]    row;
  // The 0..8 read index is kept as a row/column pair so it selects storage directly.
  logic [1:0]    idx_r, idx_c;
  logic [RW-1:0] mem [3][3];
  logic          fill_acc, drain_acc, last;
  logic [RW-1:0] raw;
  logic [DW-1:0] conv;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_ready = 1'b0;
    out_valid = 1'b0;
    fill_acc  = 1'b0;
    drain_acc = 1'b0;
    last      = (idx_r == 2'd2) && (idx_c == 2'd2);
    case (state)
      FILL: begin
        res_ready = 1'b1;
        if (res_valid && !flush) begin
          fill_acc = 1'b1;
          if (row == 2'd2) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && !flush) begin
          drain_acc = 1'b1;
          if (last) state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (flush) state_nxt = FILL;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      row   <= '0;
      idx_r <= '0;
      idx_c <= '0;
      done  <= 1'b0;
      mem   <= '{default: '0};
    end else if (flush) begin
      row   <= '0;
      idx_r <= '0;
      idx_c <= '0;
      done  <= 1'b0;
    end else begin
      done <= drain_acc && last;
      if (fill_acc) begin
        mem[row][0] <= res_in1;
        mem[row][1] <= res_in2;
        mem[row][2] <= res_in3;
        row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
      end
      if (drain_acc) begin
        if (idx_c == 2'd2) begin
          idx_c <= '0;
          idx_r <= (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
        end else begin
          idx_c <= idx_c + 2'd1;
        end
      end
    end
  end

  assign raw = mem[idx_r][idx_c];

`ifdef RESULT_BANK_SAT_EN
  assign conv = (|raw[RW-1:DW]) ? '1 : raw[DW-1:0];
`else
  assign conv = raw[DW-1:0];
`endif

  assign data_out = out_valid ? conv : '0;
  assign busy     = (state == DRAIN) || (row != 2'd0);

endmodule

// File: tb/tb_result_bank.sv
// Directed bench for result_bank: fill/drain, backpressure, conversion, flush, mid-drain reset, ignored rows.
module tb_result_bank;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       flush;
  logic [9:0] res_in1, res_in2, res_in3;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int m_seq[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int m_sat[9]  = '{300, 5, 255, 0, 0, 0, 0, 0, 0};
`ifdef RESULT_BANK_SAT_EN
  int e_sat[9]  = '{255, 5, 255, 0, 0, 0, 0, 0, 0};
`else
  int e_sat[9]  = '{44, 5, 255, 0, 0, 0, 0, 0, 0};
`endif
  int m_new[9]  = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
  int m_rst[9]  = '{21, 22, 23, 24, 25, 26, 27, 28, 29};
  int m_post[9] = '{31, 32, 33, 34, 35, 36, 37, 38, 39};

  result_bank #(.RW(10), .DW(8)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .flush     (flush),
    .res_in1   (res_in1),
    .res_in2   (res_in2),
    .res_in3   (res_in3),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Three accepted row beats; returns on the first DRAIN cycle.
  task automatic fill(input int a[9]);
    for (int r = 0; r < 3; r++) begin
      chk("fill_ready", 32'(res_ready), 1);
      res_in1   = 10'(a[3*r]);
      res_in2   = 10'(a[3*r+1]);
      res_in3   = 10'(a[3*r+2]);
      res_valid = 1'b1;
      @(negedge clk);
    end
    res_valid = 1'b0;
  endtask

  task automatic drain(input int e[9]);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_data", 32'(data_out), e[k]);
      chk("drain_done_low", 32'(done), 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("ready_after_done", 32'(res_ready), 1);
    chk("valid_after_done", 32'(out_valid), 0);
    chk("data_zero_after_done", 32'(data_out), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    clear_n   = 1'b0;
    flush     = 1'b0;
    res_in1   = '0;
    res_in2   = '0;
    res_in3   = '0;
    res_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(res_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    clear_n = 1'b1;
    @(negedge clk);

    // Basic fill and full-rate drain
    fill(m_seq);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_not_ready", 32'(res_ready), 0);
    drain(m_seq);

    // Backpressure: each word held while out_ready is low
    fill(m_seq);
    for (int k = 0; k < 9; k++) begin
      out_ready = 1'b0;
      chk("bp_data", 32'(data_out), m_seq[k]);
      chk("bp_done_low", 32'(done), 0);
      @(negedge clk);
      chk("bp_hold", 32'(data_out), m_seq[k]);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("bp_done", 32'(done), 1);
    @(negedge clk);

    // Conversion of an over-range entry
    fill(m_sat);
    drain(e_sat);

    // Flush with a simultaneous third beat
    res_in1 = 10'd1; res_in2 = 10'd2; res_in3 = 10'd3; res_valid = 1'b1;
    @(negedge clk);
    res_in1 = 10'd4; res_in2 = 10'd5; res_in3 = 10'd6;
    @(negedge clk);
    chk("pre_flush_busy", 32'(busy), 1);
    res_in1 = 10'd70; res_in2 = 10'd80; res_in3 = 10'd90; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; res_valid = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(res_ready), 1);
    fill(m_new);
    drain(m_new);

    // Asynchronous reset at idx=4
    fill(m_rst);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_data", 32'(data_out), 25);
    out_ready = 1'b0;
    clear_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_ready", 32'(res_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    fill(m_post);
    drain(m_post);

    // Rows offered during DRAIN are ignored
    fill(m_seq);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      res_in1   = 10'(100 + k);
      res_in2   = 10'(200 + k);
      res_in3   = 10'(300 + k);
      res_valid = 1'b1;
      chk("ign_data", 32'(data_out), m_seq[k]);
      @(negedge clk);
    end
    res_valid = 1'b0;
    out_ready = 1'b0;
    chk("ign_done", 32'(done), 1);
    chk("ign_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
